// File: rtl/spmv_y_axi_writer.sv
// AXI4 write master for the SpMV y-vector: streams doubles into contiguous memory
// using INCR bursts that never cross a 4 KB page, one burst outstanding at a time.
module spmv_y_axi_writer #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    n_elems,
    input  logic                y_valid,
    input  logic [DATA_W-1:0]   y_data,
    output logic                y_ready,
    output logic [ID_W-1:0]     m_axi_awid,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [ID_W-1:0]     m_axi_bid,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, FIN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr;
    logic [CNT_W-1:0]    remaining;
    logic [8:0]          beat_cnt;
    logic [ADDR_W-1:0]   awaddr_q;
    logic [7:0]          awlen_q;
    logic                err_q;
    logic                w_hs;
    logic                unused_bid;

    // Beats for the next burst: bounded by what is left, MAX_BURST and the 4 KB page end.
    function automatic logic [8:0] burst_len(input logic [ADDR_W-1:0] a,
                                             input logic [CNT_W-1:0]  rem);
        logic [12:0] page_beats;
        logic [8:0]  l;
        page_beats = (13'd4096 - {1'b0, a[11:0]}) >> 3;
        l = (rem >= CNT_W'(MAX_BURST)) ? 9'(MAX_BURST) : rem[8:0];
        if ({4'd0, l} > page_beats)
            l = page_beats[8:0];
        return l;
    endfunction

    assign w_hs       = (state == DATA) && y_valid && m_axi_wready;
    assign unused_bid = ^m_axi_bid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    err_q <= 1'b0;
                    if (n_elems != '0) begin
                        addr      <= base_addr;
                        remaining <= n_elems;
                        awaddr_q  <= base_addr;
                        awlen_q   <= 8'(burst_len(base_addr, n_elems) - 9'd1);
                    end
                end
                ADDR: if (m_axi_awready)
                    beat_cnt <= {1'b0, awlen_q} + 9'd1;
                DATA: if (w_hs) begin
                    beat_cnt  <= beat_cnt - 9'd1;
                    remaining <= remaining - CNT_W'(1);
                    addr      <= addr + ADDR_W'(8);
                end
                RESP: if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00)
                        err_q <= 1'b1;
                    // Next burst's AW fields are registered here so they are stable in ADDR.
                    if (remaining != '0) begin
                        awaddr_q <= addr;
                        awlen_q  <= 8'(burst_len(addr, remaining) - 9'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        y_ready       = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: if (start)
                state_nxt = (n_elems == '0) ? FIN : ADDR;
            ADDR: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready)
                    state_nxt = DATA;
            end
            DATA: begin
                m_axi_wvalid = y_valid;
                y_ready      = m_axi_wready;
                m_axi_wlast  = (beat_cnt == 9'd1);
                if (w_hs && beat_cnt == 9'd1)
                    state_nxt = RESP;
            end
            RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid)
                    state_nxt = (remaining != '0) ? ADDR : FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy          = (state != IDLE);
    assign err           = err_q;
    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'd3;
    assign m_axi_awburst = 2'b01;
    assign m_axi_wdata   = y_data;
    assign m_axi_wstrb   = '1;

endmodule

// File: tb/tb_spmv_y_axi_writer.sv
// Table-driven bench for spmv_y_axi_writer: an AXI slave model checks AW fields,
// W data order and wlast against hand-computed burst tables, plus reset/zero-length cases.
module tb_spmv_y_axi_writer;

    logic        clk, rst, start;
    logic [63:0] base_addr;
    logic [31:0] n_elems;
    logic        y_valid, y_ready;
    logic [63:0] y_data;
    logic [3:0]  m_axi_awid;
    logic [63:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid, m_axi_awready;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_bid;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic        busy, done, err;

    spmv_y_axi_writer dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .n_elems(n_elems),
        .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0]      base;
        int               n;
        bit               gaps;
        int               err_burst;
        bit               exp_err;
        int               n_aw;
        logic [3:0][63:0] aw_addr;
        logic [3:0][7:0]  aw_len;
    } vec_t;

    vec_t tbl[5];

    task automatic set_vec(input int idx, input logic [63:0] base, input int n, input bit gaps,
                           input int err_burst, input bit exp_err, input int n_aw,
                           input logic [63:0] a0, input logic [7:0] l0,
                           input logic [63:0] a1, input logic [7:0] l1,
                           input logic [63:0] a2, input logic [7:0] l2);
        tbl[idx].base = base;  tbl[idx].n = n;  tbl[idx].gaps = gaps;
        tbl[idx].err_burst = err_burst;  tbl[idx].exp_err = exp_err;  tbl[idx].n_aw = n_aw;
        tbl[idx].aw_addr = '0;  tbl[idx].aw_len = '0;
        tbl[idx].aw_addr[0] = a0;  tbl[idx].aw_len[0] = l0;
        tbl[idx].aw_addr[1] = a1;  tbl[idx].aw_len[1] = l1;
        tbl[idx].aw_addr[2] = a2;  tbl[idx].aw_len[2] = l2;
    endtask

    task automatic idle_inputs();
        start = 1'b0;  y_valid = 1'b0;  y_data = '0;
        m_axi_awready = 1'b0;  m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b0;  m_axi_bresp = 2'b00;  m_axi_bid = '0;
    endtask

    task automatic run_vec(input vec_t v, input int vid);
        logic [63:0] ydat[64];
        int  aw_cnt, w_cnt, b_cnt, done_cnt, beat, w_burst, b_pend, cyc;
        bit  rnd, bv;
        for (int i = 0; i < 64; i++) ydat[i] = 64'hC0DE_0000_0000_0000 | (64'(vid) << 32) | 64'(i);
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; done_cnt = 0; beat = 0; w_burst = 0; b_pend = 0;
        cyc = 0; bv = 1'b0;
        @(negedge clk);
        base_addr = v.base;  n_elems = 32'(v.n);  start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (done_cnt == 0 && cyc < 3000) begin
            rnd = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            y_valid = (w_cnt < v.n) && rnd;
            y_data  = ydat[(w_cnt < v.n) ? w_cnt : 0];
            m_axi_awready = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axi_wready  = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b_pend > 0) begin
                if (!bv) bv = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            end else bv = 1'b0;
            m_axi_bvalid = bv;
            m_axi_bresp  = (b_cnt == v.err_burst) ? 2'b10 : 2'b00;
            #1;
            chk("wvalid_before_aw", 64'(m_axi_wvalid && (aw_cnt <= w_burst)), 64'd0);
            if (m_axi_awvalid && m_axi_awready) begin
                if (aw_cnt < 4) begin
                    chk("awaddr", m_axi_awaddr, v.aw_addr[aw_cnt]);
                    chk("awlen", 64'(m_axi_awlen), 64'(v.aw_len[aw_cnt]));
                end else chk("aw_extra", 64'(aw_cnt), 64'(v.n_aw));
                chk("aw_const", {53'd0, m_axi_awid, m_axi_awsize, m_axi_awburst}, {53'd0, 4'd0, 3'd3, 2'd1});
                aw_cnt++;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                chk("wdata", m_axi_wdata, ydat[w_cnt]);
                chk("wstrb", 64'(m_axi_wstrb), 64'hFF);
                chk("wlast", 64'(m_axi_wlast), 64'(w_burst < 4 && beat == int'(v.aw_len[w_burst])));
                if (w_burst < 4 && beat == int'(v.aw_len[w_burst])) begin
                    beat = 0;  w_burst++;  b_pend++;
                end else beat++;
                w_cnt++;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_pend--;  b_cnt++;  bv = 1'b0;
            end
            if (done) done_cnt++;
            cyc++;
            @(negedge clk);
        end
        chk("timeout", 64'(cyc >= 3000), 64'd0);
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            #1;
            if (done) done_cnt++;
            @(negedge clk);
        end
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("aw_count", 64'(aw_cnt), 64'(v.n_aw));
        chk("w_count", 64'(w_cnt), 64'(v.n));
        chk("b_count", 64'(b_cnt), 64'(v.n_aw));
        chk("err", 64'(err), 64'(v.exp_err));
        chk("busy_after", 64'(busy), 64'd0);
    endtask

    initial begin
        int wcnt, cyc;
        set_vec(0, 64'h1000, 5,  1'b0, -1, 1'b0, 1, 64'h1000, 8'd4,  64'h0,    8'd0,  64'h0,    8'd0);
        set_vec(1, 64'h0,    40, 1'b0, -1, 1'b0, 3, 64'h0,    8'd15, 64'h80,   8'd15, 64'h100,  8'd7);
        set_vec(2, 64'h2000, 33, 1'b1,  1, 1'b1, 3, 64'h2000, 8'd15, 64'h2080, 8'd15, 64'h2100, 8'd0);
        set_vec(3, 64'hFF0,  8,  1'b0, -1, 1'b0, 2, 64'hFF0,  8'd1,  64'h1000, 8'd5,  64'h0,    8'd0);
        set_vec(4, 64'h4000, 2,  1'b0, -1, 1'b0, 1, 64'h4000, 8'd1,  64'h0,    8'd0,  64'h0,    8'd0);

        idle_inputs();
        base_addr = '0;  n_elems = '0;  rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {58'd0, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, y_ready, busy},
            64'd0);
        chk("rst_status", {62'd0, done, err}, 64'd0);
        chk("rst_awaddr", m_axi_awaddr, 64'd0);
        chk("rst_awlen", 64'(m_axi_awlen), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run_vec(tbl[i], i);

        // Zero-length request: done exactly one cycle after start, no AW.
        @(negedge clk);
        n_elems = '0;  base_addr = 64'h5000;  start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd1);
        chk("zero_awvalid", 64'(m_axi_awvalid), 64'd0);
        @(negedge clk);
        #1;
        chk("zero_done_after", 64'(done), 64'd0);
        chk("zero_busy_after", 64'(busy), 64'd0);

        // Reset after three beats of a 16-beat burst.
        @(negedge clk);
        base_addr = 64'h3000;  n_elems = 32'd20;  start = 1'b1;
        @(negedge clk);
        start = 1'b0;  m_axi_awready = 1'b1;  m_axi_wready = 1'b1;
        y_valid = 1'b1;  y_data = 64'hDEAD_BEEF_0000_0001;
        wcnt = 0;  cyc = 0;
        while (wcnt < 3 && cyc < 50) begin
            #1;
            if (m_axi_wvalid && m_axi_wready) wcnt++;
            cyc++;
            @(negedge clk);
        end
        chk("rst_mid_timeout", 64'(wcnt), 64'd3);
        chk("rst_mid_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mid_ctrl", {59'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, done}, 64'd0);
        chk("rst_mid_awaddr", m_axi_awaddr, 64'd0);
        rst = 1'b0;
        idle_inputs();

        run_vec(tbl[4], 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spmv_y_axi_writer.md
Name: spmv_y_axi_writer

Overview:
AXI4 write-side master for the SpMV kernel. It takes the stream of finished y-vector doubles from the multiply-accumulate stage and writes them to contiguous memory starting at a base address, using INCR bursts. It is the writing counterpart of the kernel's AXI read masters, which fetch n_cols, col_index, values and x. One burst is outstanding at a time, and a done pulse is raised after the last write response.

Parameters:
ADDR_W, 64, AXI address width
DATA_W, 64, data width; one IEEE-754 double per beat (fixed at 64)
ID_W, 4, AXI ID width; AWID driven to 0
MAX_BURST, 16, maximum beats per burst (1..256)
CNT_W, 32, width of the element-count input

Ports:
clk  in  1  kernel clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; latches base_addr and n_elems
base_addr  in  ADDR_W  byte address of y[0]; must be 8-byte aligned
n_elems  in  CNT_W  number of doubles to write
y_valid  in  1  y stream valid
y_data  in  DATA_W  y value
y_ready  out  1  y stream ready
m_axi_awid  out  ID_W  constant 0
m_axi_awaddr  out  ADDR_W  burst start address
m_axi_awlen  out  8  beats-1
m_axi_awsize  out  3  constant 3 (8 bytes)
m_axi_awburst  out  2  constant 1 (INCR)
m_axi_awvalid  out  1
m_axi_awready  in  1
m_axi_wdata  out  DATA_W  equals y_data
m_axi_wstrb  out  DATA_W/8  all ones
m_axi_wlast  out  1  last beat of burst
m_axi_wvalid  out  1
m_axi_wready  in  1
m_axi_bid  in  ID_W  ignored
m_axi_bresp  in  2
m_axi_bvalid  in  1
m_axi_bready  out  1
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after final B response
err  out  1  sticky; set if any bresp != 0; cleared by an accepted start

Behaviour:
- Reset: state IDLE. awvalid=0, wvalid=0, wlast=0, bready=0, y_ready=0, busy=0, done=0, err=0. awaddr=0, awlen=0. Counters are cleared.
- Reset mid-operation: all outputs return to the reset values on the next edge. The in-flight burst is abandoned and no done pulse is raised.
- FSM states: IDLE, ADDR, DATA, RESP, FIN.
- IDLE:
  - start with n_elems=0: go to FIN (done one cycle after start, no AXI traffic).
  - start with n_elems>0: latch addr=base_addr, remaining=n_elems, clear err, go to ADDR.
  - start while not IDLE is ignored.
- ADDR:
  - Burst length computation: len = min(remaining, MAX_BURST, (4096 - addr[11:0]) >> 3). Bursts never cross a 4 KB boundary.
  - awvalid=1, awaddr=addr, awlen=len-1. Both fields are registered and held stable until awready.
  - On the awready handshake: beat_cnt=len, go to DATA.
- DATA:
  - m_axi_wvalid = y_valid; y_ready = m_axi_wready; wdata = y_data.
  - wlast = (beat_cnt==1).
  - Each handshake decrements beat_cnt and remaining and adds 8 to addr.
  - The handshake on the last beat goes to RESP.
  - wvalid is never asserted outside DATA.
- RESP:
  - bready=1.
  - On bvalid: if bresp != 0, set err.
  - Then go to ADDR if remaining > 0, otherwise FIN.
- FIN: done=1 for one cycle, go to IDLE.
- busy = (state != IDLE).
- Stalls: no beat is dropped or duplicated under arbitrary gaps on y_valid, wready, awready or bvalid.
- Errors do not abort the transfer; remaining bursts are still issued.
- Width rules: remaining is CNT_W bits and addr is ADDR_W bits; address wrap at 2^ADDR_W is unspecified (caller's responsibility).

Test Plan:
- Single burst: base=0x1000, n=5, always ready → one AW (addr 0x1000, len 4); 5 W beats with wlast on beat 5; done 1 cycle after B; err=0.
- Multi-burst: base=0x0, n=40, MAX_BURST=16 → AWs (0x0, len 15), (0x80, len 15), (0x100, len 7); W data order matches y input exactly.
- 4 KB split: base=0xFF0, n=8 → AW (0xFF0, len 1), then AW (0x1000, len 5); wlast on beats 2 and 8.
- Backpressure and error: random 50% awready/wready/bvalid/y_valid gaps, n=33, bresp=SLVERR on burst 2 → all 33 values written in order, err=1, done pulses once.
- Zero length: start with n=0 → done high exactly 1 cycle later, awvalid never asserted, busy high for 1 cycle.
- Reset mid-burst: assert rst after 3 beats of a len-15 burst → next cycle awvalid=wvalid=bready=busy=done=0; a following start (n=2) completes normally.
